// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: the FSM state type, the grant index width, and helper functions.
// The helpers derive the bit period (BPS_CNT) and the frame length (FRAME_CYCLES).
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int GRANT_W = 3;

  // Clock cycles per serial bit.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // A frame is a start bit, 8 data bits and a stop bit.
  function automatic int calc_frame_cycles(input int bps_cnt);
    return 10 * bps_cnt;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin selector.
// The search starts at requester (last_grant+1) mod NUM_REQ and wraps around.
// Ports:
//   req        : request vector (in)
//   last_grant : index of the previous winner (in)
//   grant      : one-hot winner, all zero when there is no request (out)
//   grant_idx  : binary index of the winner (out)
//   any_req    : at least one request is present (out)
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               any_req
);

  localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned N     = NUM_REQ;

  logic        found;
  int unsigned pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    any_req   = |req;
    // Offsets 1..N from last_grant visit every requester once.
    // The last one visited is last_grant itself.
    for (int unsigned k = 1; k <= N; k++) begin
      pos = 32'(last_grant) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[IDX_W'(pos)]) begin
        found                 = 1'b1;
        grant[IDX_W'(pos)]    = 1'b1;
        grant_idx             = GRANT_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto a single UART transmitter.
// In IDLE a round-robin winner is accepted and its byte is latched.
// In SEND tx_en is held for one full frame.
// In GAP tx_en stays low for GAP_CYCLES before the next arbitration.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req_valid/req_data : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready          : one-hot accept pulse
//   tx_en/tx_din       : frame enable and byte to the transmitter
//   tx_busy            : transmitter busy flag
//   grant_id, active   : owner of the current frame, FSM not idle
//   err_timeout        : pulse when tx_busy never rose after tx_en
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_FREQ     = 50000000,
  parameter int UART_BPS     = 115200,
  parameter int GAP_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_din,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 active,
  output logic                 err_timeout
);

  localparam int BPS_CNT      = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int FRAME_CYCLES = calc_frame_cycles(BPS_CNT);
  localparam int CNT_W        = $clog2(max3(FRAME_CYCLES, GAP_CYCLES, BUSY_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_AT     = CNT_W'(BUSY_TIMEOUT);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_seen, busy_seen_n;
  logic [GRANT_W-1:0] last_grant;
  logic [NUM_REQ-1:0] grant;
  logic [GRANT_W-1:0] grant_idx;
  logic               any_req;
  logic               accept;
  logic [7:0]         sel_byte;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_byte = sel_byte | req_data[8*i +: 8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_seen  <= 1'b0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
      tx_din     <= '0;
      grant_id   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      busy_seen <= busy_seen_n;
      if (accept) begin
        last_grant <= grant_idx;
        tx_din     <= sel_byte;
        grant_id   <= grant_idx;
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    busy_seen_n = busy_seen;
    accept      = 1'b0;
    tx_en       = 1'b0;
    err_timeout = 1'b0;
    active      = (state != IDLE);
    case (state)
      IDLE: begin
        cnt_n       = '0;
        busy_seen_n = 1'b0;
        // The reset term keeps req_ready low for the whole time reset is asserted.
        // The state register alone would not do this, because IDLE is the reset state.
        if (any_req && sys_rst_n) begin
          accept  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        busy_seen_n = busy_seen | tx_busy;
        if (!busy_seen && (cnt == TMO_AT)) begin
          err_timeout = 1'b1;
          state_n     = GAP;
          cnt_n       = '0;
        end else begin
          tx_en = 1'b1;
          if (cnt == FRAME_LAST) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    req_ready = accept ? grant : '0;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Settings: BPS_CNT=10, FRAME_CYCLES=100, GAP_CYCLES=4, BUSY_TIMEOUT=8.
// Includes a small serial transmitter model that drives tx_busy and the line.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic                 sys_clk;
  logic                 sys_rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_din;
  logic                 tx_busy;
  logic [2:0]           grant_id;
  logic                 active;
  logic                 err_timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .CLK_FREQ    (1000000),
    .UART_BPS    (100000),
    .GAP_CYCLES  (4),
    .BUSY_TIMEOUT(8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_en      (tx_en),
    .tx_din     (tx_din),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .err_timeout(err_timeout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Transmitter model: starts on a rising tx_en, 10 cycles per bit, LSB first.
  logic       model_on;
  logic       tx_en_q;
  logic [9:0] msh;
  int         bcnt;
  int         nbits;
  logic       line;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_busy <= 1'b0;
      tx_en_q <= 1'b0;
      msh     <= '1;
      bcnt    <= 0;
      nbits   <= 0;
    end else begin
      tx_en_q <= tx_en;
      if (tx_busy) begin
        if (bcnt == 9) begin
          bcnt <= 0;
          if (nbits == 9) tx_busy <= 1'b0;
          else begin
            msh   <= {1'b1, msh[9:1]};
            nbits <= nbits + 1;
          end
        end else begin
          bcnt <= bcnt + 1;
        end
      end else if (model_on && tx_en && !tx_en_q) begin
        tx_busy <= 1'b1;
        msh     <= {1'b1, tx_din, 1'b0};
        bcnt    <= 0;
        nbits   <= 0;
      end
    end
  end

  assign line = tx_busy ? msh[0] : 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  logic [9:0] exp_line;
  int hi, g, nb, n, pend, last_c, gapc, erri, errc, act;
  int gids[5];
  int gcyc[5];

  initial begin
    sys_rst_n = 1'b1;
    req_valid = '0;
    req_data  = '0;
    model_on  = 1'b1;
    #1 sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_err", err_timeout, 0);
    check("rst_tx_din", tx_din, 0);

    // Single byte 0x55 from requester 0.
    @(negedge sys_clk);
    sys_rst_n     = 1'b1;
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    #1 check("t1_ready", req_ready, 4'b0001);
    @(negedge sys_clk);
    req_valid = '0;
    check("t1_ready_pulse", req_ready, 0);
    check("t1_tx_din", tx_din, 8'h55);
    check("t1_grant_id", grant_id, 0);
    exp_line = 10'b1010101010;
    hi = 0;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      if (!tx_en) break;
      hi++;
      if (i >= 6 && ((i - 6) % 10) == 0 && nb < 10) begin
        check("t1_line_bit", line, exp_line[nb]);
        nb++;
      end
      @(negedge sys_clk);
    end
    check("t1_tx_en_cycles", hi, 100);
    check("t1_bits_seen", nb, 10);
    check("t1_no_err", err_timeout, 0);
    g = 0;
    for (int i = 0; i < 50; i++) begin
      if (!active) break;
      g++;
      @(negedge sys_clk);
    end
    check("t1_gap_cycles", g, 4);

    // All four requesters valid: rotate 0,1,2,3,0 at 105-cycle spacing.
    do_reset();
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    n = 0;
    pend = -1;
    for (int c = 0; c < 700 && n < 5; c++) begin
      #1;
      if (pend >= 0) begin
        check("t2_tx_din", tx_din, 32'hA0 + 32'(pend));
        check("t2_grant_id", grant_id, 32'(pend));
        pend = -1;
      end
      if (|req_ready) begin
        check("t2_onehot", $countones(req_ready), 1);
        gids[n] = oh_idx(req_ready);
        gcyc[n] = c;
        pend = gids[n];
        n++;
      end
      @(negedge sys_clk);
    end
    #1;
    if (pend >= 0) check("t2_tx_din", tx_din, 32'hA0 + 32'(pend));
    check("t2_grant_count", n, 5);
    for (int k = 0; k < 5 && k < n; k++) check("t2_order", gids[k], k % 4);
    for (int k = 1; k < n; k++) check("t2_spacing", gcyc[k] - gcyc[k-1], 105);

    // Only requester 2 valid, back to back.
    do_reset();
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h7E, 8'h00, 8'h00};
    n = 0;
    gapc = 0;
    last_c = 0;
    for (int c = 0; c < 400 && n < 3; c++) begin
      #1;
      if (active && !tx_en) gapc++;
      if (|req_ready) begin
        check("t3_grant", req_ready, 4'b0100);
        if (n > 0) begin
          check("t3_tx_en_low_gap", gapc, 4);
          check("t3_spacing", c - last_c, 105);
        end
        last_c = c;
        gapc = 0;
        n++;
      end
      @(negedge sys_clk);
    end
    check("t3_grant_count", n, 3);

    // tx_busy never rises: timeout at SEND cycle 8.
    do_reset();
    model_on  = 1'b0;
    req_data  = {8'h00, 8'h00, 8'h3C, 8'h00};
    req_valid = 4'b0010;
    #1 check("t4_ready", req_ready, 4'b0010);
    @(negedge sys_clk);
    req_valid = '0;
    erri = -1;
    errc = 0;
    hi = 0;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      if (!active) break;
      act++;
      if (tx_en) hi++;
      if (err_timeout) begin
        errc++;
        erri = i;
        check("t4_tx_en_at_err", tx_en, 0);
      end
      @(negedge sys_clk);
    end
    check("t4_err_cycle", erri, 8);
    check("t4_err_pulses", errc, 1);
    check("t4_tx_en_cycles", hi, 8);
    check("t4_active_cycles", act, 13);
    check("t4_idle", active, 0);
    model_on = 1'b1;

    // Reset during SEND, then requester 0 wins after release.
    do_reset();
    req_data  = {8'hA3, 8'h99, 8'hA1, 8'hA0};
    req_valid = 4'b0100;
    #1 check("t5_ready", req_ready, 4'b0100);
    @(negedge sys_clk);
    req_valid = 4'b1111;
    repeat (50) @(negedge sys_clk);
    check("t5_tx_en_mid", tx_en, 1);
    check("t5_din_mid", tx_din, 8'h99);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t5_rst_tx_en", tx_en, 0);
    check("t5_rst_ready", req_ready, 0);
    check("t5_rst_active", active, 0);
    check("t5_rst_grant_id", grant_id, 0);
    @(negedge sys_clk);
    check("t5_rst_ready_hold", req_ready, 0);
    sys_rst_n = 1'b1;
    #1 check("t5_first_grant", req_ready, 4'b0001);
    @(negedge sys_clk);
    check("t5_grant_id", grant_id, 0);
    check("t5_tx_din", tx_din, 8'hA0);
    check("t5_tx_en", tx_en, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
